// File: rtl/counter_pkg.sv
// Shared constants and direction encoding for the up/down modulo counter.
//   DEFAULT_WIDTH   : default counter bit width
//   DEFAULT_MODULUS : default count range (0..MODULUS-1)
//   dir_e           : count direction encoding (DIR_DOWN=0, DIR_UP=1)
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 4;
    localparam int unsigned DEFAULT_MODULUS = 10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/t_cell.sv
// Single-bit toggle register used as one bit of the counter.
// Holds no knowledge of the modulus; the top decides which bits toggle.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset (q -> 0)
//   load_en : load d on this edge (overrides toggle)
//   d       : load data
//   t       : toggle enable (q -> ~q)
//   q       : registered bit value
module t_cell (
    input  logic clk,
    input  logic reset,
    input  logic load_en,
    input  logic d,
    input  logic t,
    output logic q
);

    // Priority: reset > load > toggle > hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (load_en) begin
            q <= d;
        end else begin
            q <= q ^ t;
        end
    end

endmodule : t_cell

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter built from per-bit toggle cells.
// Optional macro UPDOWN_COUNTER_GRAY_OUT_EN adds a registered Gray-coded copy
// of the count (count_gray); without it the port is absent.
// Parameters:
//   WIDTH   : counter width (2..16)
//   MODULUS : count range 0..MODULUS-1 (2..2**WIDTH)
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   en         : count enable
//   up_dn      : 1 = up, 0 = down
//   load       : synchronous parallel load request (beats en)
//   load_val   : value to load (values >= MODULUS load 0)
//   count      : registered current count
//   t_vec      : combinational per-bit toggle enables (count ^ next_count)
//   tc         : combinational terminal-count flag
//   count_gray : registered Gray code of count (macro only)
//   wrap       : registered one-cycle pulse after a wrap-around edge
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc,
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             wrap
);

    // One extra bit so MODULUS == 2**WIDTH is representable
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    dir_e             dir;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] next_count;
    logic             at_wrap;

    assign dir = dir_e'(up_dn);

    // Out-of-range load values collapse to 0
    assign load_data = ({1'b0, load_val} >= MOD_EXT) ? '0 : load_val;

    // Wrap point depends on direction
    always_comb begin
        at_wrap = 1'b0;
        case (dir)
            DIR_UP:   at_wrap = (count == MAX_VAL);
            DIR_DOWN: at_wrap = (count == '0);
            default:  at_wrap = 1'b0;
        endcase
    end

    // Functional next count (reset handled inside the registers)
    always_comb begin
        next_count = count;
        if (load) begin
            next_count = load_data;
        end else if (en) begin
            case (dir)
                DIR_UP:   next_count = at_wrap ? '0 : count + WIDTH'(1);
                DIR_DOWN: next_count = at_wrap ? MAX_VAL : count - WIDTH'(1);
                default:  next_count = count;
            endcase
        end
    end

    assign t_vec = count ^ next_count;
    assign tc    = en & ~load & at_wrap;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        t_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .load_en (load),
            .d       (load_data[i]),
            .t       (t_vec[i]),
            .q       (count[i])
        );
    end

    // Wrap pulse follows any edge taken while tc was high
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    // Gray register tracks next_count so it stays in phase with count
    always_ff @(posedge clk) begin
        if (reset) begin
            count_gray <= '0;
        end else begin
            count_gray <= next_count ^ (next_count >> 1);
        end
    end
`endif

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10).
// Build with UPDOWN_COUNTER_GRAY_OUT_EN defined to also cover count_gray.
module tb_updown_mod_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic [3:0] t_vec;
    logic       tc;
    logic       wrap;
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
    logic [3:0] count_gray;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .up_dn      (up_dn),
        .load       (load),
        .load_val   (load_val),
        .count      (count),
        .t_vec      (t_vec),
        .tc         (tc),
`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
        .count_gray (count_gray),
`endif
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] up_cnt  [12];
        logic [3:0] up_tv   [12];
        logic [3:0] dn_cnt  [9];
        logic [3:0] gray_tb [10];

        up_cnt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        // toggle vector for each step, i.e. previous ^ next
        up_tv   = '{4'h1, 4'h3, 4'h1, 4'h7, 4'h1, 4'h3, 4'h1, 4'hF, 4'h1, 4'h9, 4'h1, 4'h3};
        dn_cnt  = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
        gray_tb = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13};

        // Reset held 2 cycles with en=1
        reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_count", 16'(count), 16'd0);
            chk("rst_wrap",  16'(wrap),  16'd0);
        end
        reset = 1'b0;
        tick();
        chk("post_rst_count", 16'(count), 16'd1);

        // Back to 0, then 12 up steps
        reset = 1'b1;
        tick();
        chk("rst2_count", 16'(count), 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("up_tc",   16'(tc),    (i == 9) ? 16'd1 : 16'd0);
            chk("up_tvec", 16'(t_vec), 16'(up_tv[i]));
            tick();
            chk("up_count", 16'(count), 16'(up_cnt[i]));
            chk("up_wrap",  16'(wrap),  (i == 9) ? 16'd1 : 16'd0);
        end

        // Load 7, then 9 down steps
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        tick();
        chk("load7", 16'(count), 16'd7);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("dn_tc", 16'(tc), (i == 7) ? 16'd1 : 16'd0);
            if (i == 7) chk("dn_tvec_wrap", 16'(t_vec), 16'h9);
            tick();
            chk("dn_count", 16'(count), 16'(dn_cnt[i]));
            chk("dn_wrap",  16'(wrap),  (i == 7) ? 16'd1 : 16'd0);
        end

        // Load beats en; out-of-range value loads 0
        load = 1'b1; load_val = 4'd12;
        tick();
        chk("load12", 16'(count), 16'd0);
        #1;
        chk("load_blocks_tc", 16'(tc), 16'd0);
        load_val = 4'd5;
        tick();
        chk("load5", 16'(count), 16'd5);
        chk("load5_wrap", 16'(wrap), 16'd0);

        // Hold with en=0
        load = 1'b0; en = 1'b0;
        #1;
        chk("hold_tvec", 16'(t_vec), 16'd0);
        tick();
        chk("hold_count", 16'(count), 16'd5);

        // Direction change takes effect on the same edge
        en = 1'b1; up_dn = 1'b1;
        tick();
        chk("dir_up", 16'(count), 16'd6);
        up_dn = 1'b0;
        tick();
        chk("dir_dn", 16'(count), 16'd5);

        // Reset overrides load at count=6
        load = 1'b1; load_val = 4'd6; en = 1'b0;
        tick();
        chk("load6", 16'(count), 16'd6);
        reset = 1'b1; load_val = 4'd3;
        tick();
        chk("rst_vs_load", 16'(count), 16'd0);
        reset = 1'b0; load = 1'b0; en = 1'b0;
        #1;
        chk("rst_tvec", 16'(t_vec), 16'd0);
        chk("rst_tc",   16'(tc),    16'd0);

        // Reset while tc is high suppresses wrap
        en = 1'b1; up_dn = 1'b0; reset = 1'b1;
        tick();
        chk("rst_tc_wrap", 16'(wrap), 16'd0);
        reset = 1'b0; en = 1'b0;

`ifdef UPDOWN_COUNTER_GRAY_OUT_EN
        reset = 1'b1;
        tick();
        chk("gray_rst", 16'(count_gray), 16'd0);
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i < 10; i++) begin
            tick();
            chk("gray_cnt", 16'(count),      16'(i));
            chk("gray_val", 16'(count_gray), 16'(gray_tb[i]));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_updown_mod_counter

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, is the counter bit width (range 2..16).
REQ-002 Parameter MODULUS, default 10, is the count range 0..MODULUS-1 (range 2..2**WIDTH).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port en, input, 1 bit: count enable.
REQ-006 Port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-007 Port load, input, 1 bit: synchronous parallel load request.
REQ-008 Port load_val, input, WIDTH bits: value to load.
REQ-009 Port count, output, WIDTH bits: registered current count.
REQ-010 Port t_vec, output, WIDTH bits: per-bit toggle enables for the next edge, used to drive downstream toggle cells.
REQ-011 Port tc, output, 1 bit: combinational terminal-count flag.
REQ-012 Port wrap, output, 1 bit: registered one-cycle pulse after a wrap-around.

Function
REQ-013 Priority per edge SHALL be reset > load > en > hold.
REQ-014 With load=1, count SHALL take load_val next edge; load_val >= MODULUS SHALL load 0.
REQ-015 With en=1, up_dn=1: count+1, and MODULUS-1 SHALL wrap to 0.
REQ-016 With en=1, up_dn=0: count-1, and 0 SHALL wrap to MODULUS-1.
REQ-017 With en=0 and load=0, count SHALL hold.
REQ-018 t_vec SHALL equal count XOR next_count, combinationally, so it is all-zero when holding.
REQ-019 tc SHALL be 1 iff en=1, load=0, and count is at the wrap point for the current up_dn (MODULUS-1 up, 0 down).
REQ-020 wrap SHALL be 1 for exactly the one cycle after an edge at which tc was 1, else 0.
REQ-021 Direction change mid-count SHALL take effect on the same edge, with no extra latency.
REQ-022 Latency: load and count steps are visible on count one edge after the request.

Reset
REQ-023 On a reset edge: count=0 and wrap=0. t_vec and tc then follow REQ-018/019 from count=0.
REQ-024 Reset SHALL override a simultaneous load or en.
REQ-025 Reset mid-count SHALL discard all state, and counting SHALL resume from 0 on the first non-reset edge.

Configuration
REQ-026 Macro UPDOWN_COUNTER_GRAY_OUT_EN, when defined, SHALL add output count_gray (WIDTH bits) = count ^ (count >> 1), registered in phase with count and reset to 0.
REQ-027 Without UPDOWN_COUNTER_GRAY_OUT_EN, count_gray SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 Package counter_pkg SHALL hold the default WIDTH/MODULUS constants and the direction encoding (DIR_DOWN=0, DIR_UP=1).
REQ-029 Each count bit SHALL be a sub-module t_cell: a toggle register with synchronous active-high reset, load-enable and data inputs, and a toggle input driven from t_vec.
REQ-030 The next-count and wrap logic SHALL live in the top module; t_cell SHALL contain no modulus knowledge.

Verification (WIDTH=4, MODULUS=10)
REQ-031 Reset asserted for 2 cycles with en=1 -> count=0, wrap=0 throughout; after release with up_dn=1, count=1 at the next edge.
REQ-032 en=1, up_dn=1 for 12 edges from 0 -> count 1..9,0,1,2; tc=1 only while count=9; wrap pulses once, in the cycle count=0.
REQ-033 Load 7 then en=1, up_dn=0 for 9 edges -> 7,6..0,9,8; tc at count=0; t_vec=4'b1001 on the 0->9 step.
REQ-034 load=1 and en=1 with load_val=12 -> count=0 next edge; load_val=5 with en=1 -> count=5 (load wins).
REQ-035 Reset asserted in the same cycle as load=1, load_val=3 at count=6 -> count=0; with en=0, t_vec=0 and tc=0.
REQ-036 With UPDOWN_COUNTER_GRAY_OUT_EN defined, counting 0..9 -> count_gray = 0,1,3,2,6,7,5,4,12,13, matching count at every edge.
